alu_issue_queue: RTL
====================

// Module: alu_issue_queue
// PURPOSE
//  Command FIFO directly upstream of the 16-bit ALU. Buffers {a, b, selection} commands from the
//  producer over a valid/ready handshake and presents the head command to the ALU's a/b/selection.
//  Screens illegal commands at push time: opcode 4'b1111, and DIVISION/MODULUS with b==0.
//  Flagged commands are dropped and reported, so the ALU never sees them.
// PARAMETERS
//  DEPTH  8   entries; power of 2, >=2
//  W      16  operand width (matches ALU a/b)
//  OPW    4   opcode width (matches ALU selection)
// PORTS
//  clk       in   1                 rising-edge clock
//  rst       in   1                 asynchronous, active-high reset
//  flush     in   1                 synchronous clear of all entries
//  in_valid  in   1                 producer command valid
//  in_ready  out  1                 queue can accept (= !full)
//  in_a      in   W                 operand a
//  in_b      in   W                 operand b
//  in_sel    in   OPW               ALU opcode (0000 ADD .. 1110 INVERT)
//  out_valid out  1                 head command valid (= count!=0)
//  out_ready in   1                 ALU stage consumes head
//  out_a     out  W                 head operand a; 0 when empty
//  out_b     out  W                 head operand b; 0 when empty
//  out_sel   out  OPW               head opcode; 0 when empty
//  count     out  $clog2(DEPTH)+1   stored entries, 0..DEPTH
//  rej       out  1                 1-cycle pulse: command dropped
//  rej_code  out  2                 01 illegal opcode, 10 div/mod by zero; held until next rej
// BEHAVIOUR
//  - Reset (async): rd/wr pointers=0, count=0, out_valid=0, out_*=0, rej=0, rej_code=00.
//  - Push: in_valid&&in_ready at posedge. Legal command -> written at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//  - Illegal command still completes the handshake (in_ready unaffected) but is not stored.
//    Next cycle: rej=1, rej_code updated. count and pointers unchanged.
//  - Reject priority: opcode 1111 (code 01) over div/mod-by-zero (code 10). 0011/0100 with in_b==0 -> code 10.
//  - Pop: out_valid&&out_ready at posedge -> rd_ptr++ (wraps).
//  - Show-ahead output: out_* = mem[rd_ptr] combinationally, masked to 0 when empty.
//    Latency push->out_valid = 1 cycle. No same-cycle bypass when empty.
//  - Stability: while out_valid&&!out_ready, out_a/out_b/out_sel/out_valid hold.
//  - Full: in_ready=0 when count==DEPTH, even if a pop occurs that cycle (no full-bypass).
//  - Simultaneous legal push+pop with 0<count<DEPTH -> count unchanged; both pointers advance.
//  - flush: next cycle pointers=0, count=0, out_valid=0. Push and pop in the flush cycle are ignored.
//    No rej is generated in a flush cycle; rej_code holds.
//  - rst mid-transfer: all entries lost, outputs return to reset values immediately.
// CONFIGURATION
//  ALU_ISSUE_STATS_EN defined: adds outputs hwm[$clog2(DEPTH):0] and rej_cnt[15:0].
//    hwm = max count since reset/flush. rej_cnt = number of rej pulses, saturating at 16'hFFFF.
//    flush clears hwm only. rst clears both.
//  Undefined: those ports and their logic are absent. All other behaviour is identical.
// TESTING
//  1. After rst, push a=5,b=3,sel=0000 -> next cycle out_valid=1, out_a=5, out_b=3, out_sel=0, count=1.
//  2. Push 8 legal commands with out_ready=0 -> count=8, in_ready=0.
//     9th in_valid is not accepted. Then pop all 8 -> original order, count=0, out_*=0.
//  3. Push sel=1111 -> rej=1 for 1 cycle, rej_code=01, count unchanged.
//     Push sel=0011,b=0 -> rej_code=10. Push sel=0100,b=0 -> rej_code=10.
//  4. count=4, push+pop same cycle for 20 cycles -> count stays 4, pointers wrap, FIFO order preserved.
//  5. count=6, flush with in_valid=1 -> next cycle count=0, out_valid=0, pushed data absent.
//  6. ALU_ISSUE_STATS_EN: fill to 5, drain, 3 rejects -> hwm=5, rej_cnt=3. flush -> hwm=0, rej_cnt=3.

Source files
------------

// File: rtl/alu_issue_queue.sv
// -----------------------------------------------------------------------------
// alu_issue_queue
//   Command FIFO in front of the 16-bit ALU. Accepts {a, b, sel} commands over
//   a valid/ready handshake and presents the head command show-ahead style.
//   Illegal commands are screened at push time. They are accepted by the
//   handshake but never stored, and each one is reported by a one-cycle
//   pulse on rej together with a held reason code.
//     - opcode all-ones                       -> rej_code 01
//     - DIVISION (0011) / MODULUS (0100), b==0 -> rej_code 10
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   flush                 synchronous clear; push/pop in that cycle ignored
//   in_valid/in_ready     producer handshake (in_ready = !full)
//   in_a, in_b, in_sel    command operands and opcode
//   out_valid/out_ready   consumer handshake (out_valid = count != 0)
//   out_a, out_b, out_sel head command, forced to 0 when empty
//   count                 stored entries, 0..DEPTH
//   rej, rej_code         drop pulse and reason of the most recent drop
//
// Configuration
//   ALU_ISSUE_STATS_EN    adds hwm (max count since reset/flush) and rej_cnt
//                         (saturating drop counter; cleared by rst only).
// -----------------------------------------------------------------------------
module alu_issue_queue #(
  parameter int DEPTH = 8,
  parameter int W     = 16,
  parameter int OPW   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  input  logic [OPW-1:0]           in_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_a,
  output logic [W-1:0]             out_b,
  output logic [OPW-1:0]           out_sel,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     rej,
  output logic [1:0]               rej_code
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   hwm,
  output logic [15:0]              rej_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [OPW-1:0] OP_DIV     = OPW'(3);
  localparam logic [OPW-1:0] OP_MOD     = OPW'(4);
  localparam logic [OPW-1:0] OP_ILLEGAL = '1;

  localparam logic [1:0] REJ_OPCODE = 2'b01;
  localparam logic [1:0] REJ_DIV0   = 2'b10;

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [OPW-1:0] sel;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  cmd_t          head;

  logic full;
  logic push_fire;   // handshake completes, legal or not
  logic bad_opcode;
  logic div_by_zero;
  logic illegal;
  logic push_legal;
  logic pop;

  // ---------------------------------------------------------------------------
  // Handshake and screening
  // ---------------------------------------------------------------------------
  assign full      = (count == CW'(DEPTH));
  // A pop in the same cycle does not open a slot: no full-bypass.
  assign in_ready  = !full;
  assign out_valid = (count != '0);

  assign bad_opcode  = (in_sel == OP_ILLEGAL);
  assign div_by_zero = ((in_sel == OP_DIV) || (in_sel == OP_MOD)) && (in_b == '0);
  assign illegal     = bad_opcode || div_by_zero;

  // flush suppresses every state change that the handshake would cause,
  // including the reject report.
  assign push_fire  = in_valid && in_ready && !flush;
  assign push_legal = push_fire && !illegal;
  assign pop        = out_valid && out_ready && !flush;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      unique case ({push_legal, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads the pre-edge values of the others regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rej      <= 1'b0;
      rej_code <= 2'b00;
    end else begin
      count <= count_next;
      rej   <= push_fire && illegal;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_legal) wr_ptr <= wr_ptr + AW'(1);
        if (pop)        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_fire && illegal) begin
        rej_code <= bad_opcode ? REJ_OPCODE : REJ_DIV0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the payload array has no reset; an entry is only ever observed
  // after it was written, and out_* is masked to 0 while the queue is empty.
  always_ff @(posedge clk) begin
    if (push_legal) begin
      mem[wr_ptr] <= '{a: in_a, b: in_b, sel: in_sel};
    end
  end

  // Show-ahead read; no same-cycle bypass from the input when empty.
  assign head    = mem[rd_ptr];
  assign out_a   = out_valid ? head.a   : '0;
  assign out_b   = out_valid ? head.b   : '0;
  assign out_sel = out_valid ? head.sel : '0;

`ifdef ALU_ISSUE_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  // hwm tracks count_next so it moves in the same cycle as count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm     <= '0;
      rej_cnt <= '0;
    end else begin
      if (flush) begin
        hwm <= '0;
      end else if (count_next > hwm) begin
        hwm <= count_next;
      end
      // Counted when the pulse is scheduled, so it updates alongside rej.
      if (push_fire && illegal && (rej_cnt != 16'hFFFF)) begin
        rej_cnt <= rej_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
